// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order word-aligned requests to instruction memory under a credit limit,
// buffers returned words with their PCs, and supports a single-cycle flush. Optional IFETCH_LOG_EN adds sim logging.
module instr_fetch_unit #(
    parameter int unsigned DEPTH       = 2,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic [31:0] i_pc,
    input  logic        i_pc_valid,
    output logic        o_pc_ready,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_dbg_state
);
    // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
    // rising edge; valid never depends on ready on the same channel.

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] tag_wr_q, tag_rd_q;
    logic [AW-1:0] fifo_wr_q, fifo_rd_q;
    logic [31:0]   tag_mem_q   [DEPTH];
    logic [31:0]   fifo_instr_q[DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic          credit_ok;
    logic          req_hs;
    logic          rsp_accept;
    logic          rsp_drop;
    logic          fifo_pop;
    logic [CW-1:0] inflight;
    logic [CW-1:0] flush_discard;

    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_W;

    assign o_imem_req_valid = i_pc_valid && credit_ok && (state_q == ST_RUN) && !i_flush;
    assign o_imem_req_addr  = {i_pc[31:2], 2'b00};
    assign o_pc_ready       = o_imem_req_valid && i_imem_req_ready;
    assign req_hs           = o_pc_ready;

    // A response with nothing outstanding or discarding is ignored.
    assign rsp_accept = i_imem_rsp_valid && (state_q == ST_RUN) && (outstanding_q != '0) && !i_flush;
    assign rsp_drop   = i_imem_rsp_valid && (state_q == ST_DRAIN) && (discard_q != '0);

    assign o_instr_valid = (fifo_cnt_q != '0);
    assign o_instr       = o_instr_valid ? fifo_instr_q[fifo_rd_q] : RESET_INSTR;
    assign o_instr_pc    = o_instr_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    assign fifo_pop      = o_instr_valid && i_instr_ready;

    // Only one of the two counters is non-zero at any time, so the sum never overflows.
    assign inflight      = outstanding_q + discard_q;
    assign flush_discard = inflight - CW'(i_imem_rsp_valid && (inflight != '0));

    assign o_busy      = (outstanding_q != '0) || (discard_q != '0) || (fifo_cnt_q != '0);
    assign o_dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (i_flush) begin
            outstanding_d = '0;
            discard_d     = flush_discard;
            state_d       = (flush_discard != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_accept);
                end
                ST_DRAIN: begin
                    if (discard_q == '0) begin
                        state_d = ST_RUN;
                    end else if (rsp_drop) begin
                        discard_d = discard_q - 1'b1;
                        if (discard_q == CW'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (i_flush) begin
            fifo_cnt_d = '0;
        end else begin
            fifo_cnt_d = fifo_cnt_q + CW'(rsp_accept) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q       <= ST_RUN;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (i_flush) begin
                tag_wr_q  <= '0;
                tag_rd_q  <= '0;
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (req_hs)     tag_wr_q  <= tag_wr_q + 1'b1;
                if (rsp_accept) tag_rd_q  <= tag_rd_q + 1'b1;
                if (rsp_accept) fifo_wr_q <= fifo_wr_q + 1'b1;
                if (fifo_pop)   fifo_rd_q <= fifo_rd_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while the matching counter says they are valid.
    always_ff @(posedge i_clock) begin
        if (req_hs) begin
            tag_mem_q[tag_wr_q] <= o_imem_req_addr;
        end
        if (rsp_accept) begin
            fifo_instr_q[fifo_wr_q] <= i_imem_rsp_data;
            fifo_pc_q[fifo_wr_q]    <= tag_mem_q[tag_rd_q];
        end
    end

`ifdef IFETCH_LOG_EN
    always @(posedge i_clock) begin
        if (i_resetn && o_instr_valid && i_instr_ready) begin
            $display("%t IF pc=0x%8h instr=0x%8h", $time, o_instr_pc, o_instr);
        end
        if (i_resetn && i_flush) begin
            $display("%t IF flush discard=%0d", $time, flush_discard);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a queue-based memory/decode model.
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_resetn;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic        o_pc_ready;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;
    logic        i_flush;
    logic        o_busy;
    logic        o_dbg_state;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_INSTR(NOP)) dut (
        .i_clock(clk), .i_resetn(i_resetn),
        .i_pc(i_pc), .i_pc_valid(i_pc_valid), .o_pc_ready(o_pc_ready),
        .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
        .i_imem_req_ready(i_imem_req_ready),
        .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready), .i_flush(i_flush),
        .o_busy(o_busy), .o_dbg_state(o_dbg_state)
    );

    // Memory requests in flight; keep=0 marks a response that a flush has orphaned.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          keep;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];   // {instr, pc} words the decode side should see, in order
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          hs_seen = 0;
    logic [31:0] next_pc = 32'h0;
    bit          pv_g = 0, rr_g = 0, ir_g = 0, rnd = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int kept_count();
        int n = 0;
        foreach (mem_q[k]) if (mem_q[k].keep) n++;
        return n;
    endfunction

    // One clock: drive inputs at negedge, check outputs 1 time unit later, then advance the model.
    task automatic tick(input bit fl, input bit spur);
        bit          have_rsp, drain, exp_rv, exp_hs, exp_iv;
        int          outst, due;
        logic [31:0] rdata;
        logic [63:0] head;
        mreq_t       e;
        @(negedge clk);
        if (rnd) begin
            pv_g = ($urandom_range(0, 3) != 0);
            rr_g = ($urandom_range(0, 3) != 0);
            ir_g = ($urandom_range(0, 2) != 0);
        end
        have_rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdata    = have_rsp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        i_imem_rsp_valid = have_rsp || spur;
        i_imem_rsp_data  = rdata;
        i_pc_valid       = pv_g;
        i_pc             = next_pc;
        i_imem_req_ready = rr_g;
        i_instr_ready    = ir_g;
        i_flush          = fl;
        #1;
        outst = 0;
        drain = 0;
        foreach (mem_q[k]) begin
            if (mem_q[k].keep) outst++;
            else drain = 1;
        end
        exp_rv = pv_g && !fl && !drain && ((outst + exp_q.size()) < DEPTH);
        exp_hs = exp_rv && rr_g;
        exp_iv = (exp_q.size() > 0);
        head   = exp_iv ? exp_q[0] : {NOP, 32'h0};
        chk("req_valid", o_imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", o_imem_req_addr, {next_pc[31:2], 2'b00});
        chk("pc_ready", o_pc_ready, exp_hs);
        chk("instr_valid", o_instr_valid, exp_iv);
        chk("instr", o_instr, head[63:32]);
        chk("instr_pc", o_instr_pc, head[31:0]);
        chk("busy", o_busy, (outst > 0) || drain || exp_iv);
        chk("state_drain", o_dbg_state, drain);
        if (o_pc_ready === 1'b1) hs_seen++;
        @(posedge clk);
        if (exp_iv && ir_g) void'(exp_q.pop_front());
        if (have_rsp) begin
            e = mem_q.pop_front();
            if (e.keep && !fl) exp_q.push_back({rdata, e.addr});
        end
        if (fl) begin
            exp_q.delete();
            foreach (mem_q[k]) mem_q[k].keep = 0;
        end
        if (exp_hs) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{addr: {next_pc[31:2], 2'b00}, due: due, keep: 1'b1});
            last_due = due;
            next_pc  = next_pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        int n;
        bit fl;
        i_resetn = 1'b0;
        i_pc = '0; i_pc_valid = 0; i_imem_req_ready = 0; i_imem_rsp_valid = 0;
        i_imem_rsp_data = '0; i_instr_ready = 0; i_flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_valid", o_instr_valid, 1'b0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_instr_pc", o_instr_pc, 32'h0);
        chk("rst_req_valid", o_imem_req_valid, 1'b0);
        chk("rst_pc_ready", o_pc_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_state", o_dbg_state, 1'b0);
        i_resetn = 1'b1;

        // Streaming fetch: PC 0,4,8,... with 1-cycle memory and ready decode.
        lat = 1; pv_g = 1; rr_g = 1; ir_g = 1; next_pc = 32'h0;
        repeat (10) tick(0, 0);

        // Decode stall: only DEPTH requests may issue, then flow resumes.
        pv_g = 0;
        repeat (4) tick(0, 0);
        hs_seen = 0; ir_g = 0; pv_g = 1;
        repeat (6) tick(0, 0);
        chk("stall_req_count", hs_seen, DEPTH);
        ir_g = 1;
        repeat (8) tick(0, 0);

        // Flush with two responses outstanding at latency 3, then redirect to 0x100.
        pv_g = 0;
        repeat (5) tick(0, 0);
        lat = 3; pv_g = 1;
        repeat (2) tick(0, 0);
        next_pc = 32'h100;
        tick(1, 0);
        repeat (10) tick(0, 0);

        // Flush coinciding with the only outstanding response.
        pv_g = 0;
        repeat (6) tick(0, 0);
        lat = 1; pv_g = 1;
        tick(0, 0);
        pv_g = 0;
        tick(1, 0);
        repeat (2) tick(0, 0);

        // Misaligned PC is fetched word-aligned.
        next_pc = 32'h0000_0006; pv_g = 1;
        repeat (6) tick(0, 0);

        // Randomized traffic with occasional flushes and stray responses.
        rnd = 1;
        for (int i = 0; i < 500; i++) begin
            lat = $urandom_range(1, 4);
            fl  = ($urandom_range(0, 19) == 0);
            tick(fl, (mem_q.size() == 0) && ($urandom_range(0, 29) == 0));
            if (fl) next_pc = $urandom;
        end
        rnd = 0;

        // Reset with the FIFO holding a word and one request outstanding.
        pv_g = 0; ir_g = 1;
        repeat (8) tick(0, 0);
        lat = 3; pv_g = 1; rr_g = 1; ir_g = 0;
        n = 0;
        while (!(exp_q.size() == 1 && kept_count() == 1) && n < 40) begin
            tick(0, 0);
            n++;
        end
        chk("reset_setup_reached", (n < 40), 1'b1);
        @(negedge clk);
        #2;
        i_pc_valid = 0; i_imem_rsp_valid = 0; i_flush = 0;
        i_resetn = 1'b0;
        #1;
        chk("midrst_instr_valid", o_instr_valid, 1'b0);
        chk("midrst_instr", o_instr, NOP);
        chk("midrst_instr_pc", o_instr_pc, 32'h0);
        chk("midrst_req_valid", o_imem_req_valid, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_state", o_dbg_state, 1'b0);
        exp_q.delete();
        mem_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_resetn = 1'b1;
        cyc += 4;
        last_due = cyc;
        pv_g = 0; ir_g = 1;
        tick(0, 1);
        repeat (2) tick(0, 0);
        chk("post_spurious_busy", o_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
